loop_sequencer: RTL
===================

Name: loop_sequencer

Overview:
- Control block for the audio loop datapath. Paces the codec read/write handshake and runs the record/play/stop state machine.
- Generates address and enable strobes for the loop sample memory, including forward or reverse playback.
- Sits between the codec interface, the user controls (push-button, clear, reverse switch) and the loop buffer memories (left/right share one address stream).

Parameters:
- ADDR_W, 16, loop memory address width
- MAX_LEN, 48000, maximum loop length in samples (≤ 2^ADDR_W)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-low reset
- btn  in  1  record/play/stop button, active-high, already synchronised to clk
- clear  in  1  synchronous loop erase, active-high
- reverse  in  1  1 = play loop backwards
- overdub  in  1  overdub request; used only when LOOP_OVERDUB_EN is defined
- read_ready  in  1  codec ADC sample available
- write_ready  in  1  codec DAC can accept a sample
- codec_read  out  1  pulse to codec read
- codec_write  out  1  pulse to codec write
- mem_addr  out  ADDR_W  loop memory address
- mem_we  out  1  loop memory write strobe
- mem_re  out  1  loop memory read strobe
- mix_en  out  1  datapath adds live input to loop data before write (overdub)
- play_valid  out  1  1 = output mux selects loop data, 0 = passthrough
- loop_len  out  ADDR_W+1  recorded loop length in samples
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, all strobes 0, mem_addr=0, loop_len=0, play_valid=0, btn edge register cleared.
- Button press = rising edge of btn (btn==1, previous-cycle btn==0). One press yields exactly one transition.
- Sample tick at cycle T requires all of: read_ready==1, write_ready==1, codec_read==0 in cycle T.
- Response to a tick at T, all registered, all active only in T+1:
  - codec_read=1 and codec_write=1 for exactly one cycle.
  - mem_addr holds the current pointer throughout T+1.
  - RECORD: mem_we=1. PLAY: mem_re=1.
  - Pointer updates at the end of T+1.
- A tick is never issued in the cycle directly after codec_read. There is at most one tick per two cycles.
- IDLE:
  - Press with loop_len==0 → RECORD, ptr=0.
  - Press with loop_len>0 → PLAY, ptr=0 (forward) or loop_len-1 (reverse).
  - No memory strobes in IDLE; codec ticks still run (passthrough).
- RECORD:
  - Each tick writes at ptr, then ptr+1.
  - Press → PLAY with loop_len=ptr and ptr reset as in the IDLE rule. If ptr==0, go to IDLE instead.
  - Write at ptr==MAX_LEN-1 → auto PLAY, loop_len=MAX_LEN.
- PLAY:
  - play_valid=1.
  - Forward: ptr wraps loop_len-1 → 0.
  - Reverse: ptr wraps 0 → loop_len-1.
  - Toggling reverse mid-loop changes direction from the current ptr at the next tick; there is no jump.
  - Press → IDLE; loop_len is kept.
- clear==1: any state → IDLE, loop_len=0, ptr=0. clear has priority over btn and over tick strobes in the same cycle, so strobes are suppressed.
- Press coinciding with a tick:
  - The tick's memory strobe completes under the old state.
  - The transition is taken at the same edge.
  - A RECORD→PLAY press counts that final write in loop_len.
- Reset mid-operation aborts any strobe; loop_len is lost.
- loop_len never exceeds MAX_LEN. Pointer arithmetic is unsigned ADDR_W+1 bits, compared before increment.

Optional Feature:
- Macro: LOOP_OVERDUB_EN.
- Defined: in PLAY with overdub==1, each tick performs a read-modify-write on the same address:
  - mem_re at T+1.
  - mem_we and mix_en at T+3, mem_addr held T+1..T+3.
  - Pointer advances after T+3.
  - Ticks are blocked until the write completes.
  - Dropping overdub mid-sequence finishes the pending write.
- Undefined: overdub is ignored, mix_en is tied 0, and mem_we is never asserted in PLAY.

Test Plan:
- Reset low 2 cycles with ready inputs high → all outputs 0, state=00; after release, codec_read/codec_write pulse 1 cycle, never on consecutive cycles.
- Press, 5 ticks, press → mem_we at addresses 0..4, state=10, loop_len=5; next 7 ticks mem_re at 0,1,2,3,4,0,1.
- Loop_len=5 in PLAY, reverse=1 at ptr=2 → subsequent reads 2,1,0,4,3; reverse=0 → resumes upward from the current ptr.
- MAX_LEN=8, record without second press → writes 0..7, auto PLAY, loop_len=8; press in RECORD with zero ticks → IDLE, loop_len=0.
- clear asserted in the same cycle as a tick during PLAY → no strobes that cycle, state=00, loop_len=0; next press enters RECORD.
- With LOOP_OVERDUB_EN, loop_len=4, overdub=1, tick at T → mem_re T+1 addr 0, mem_we+mix_en T+3 addr 0, no codec pulse T+1..T+3 beyond the first; without the macro, mix_en stays 0.

Source files
------------

// File: rtl/loop_sequencer.sv
// loop_sequencer: paces the codec read/write handshake, runs the
// record/play/stop state machine and drives address and strobes for the loop
// sample memory (forward or reverse playback).
// Optional overdub read-modify-write is built when LOOP_OVERDUB_EN is defined.
module loop_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 48000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn,
    input  logic              clear,
    input  logic              reverse,
    input  logic              overdub,
    input  logic              read_ready,
    input  logic              write_ready,
    output logic              codec_read,
    output logic              codec_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic              mix_en,
    output logic              play_valid,
    output logic [ADDR_W:0]   loop_len,
    output logic [1:0]        state
);

    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_LEN);
    localparam logic [LW-1:0] ONE       = LW'(1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RECORD = 2'b01;
    localparam logic [1:0] ST_PLAY   = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [LW-1:0]     ptr_q, ptr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              btn_q;
    logic              pulse_q, pulse_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              press, tick;
    logic [LW-1:0]     rec_len;
    logic              od_busy, od_hold, od_we;

    // First address of a playback pass: 0 forward, last sample in reverse.
    function automatic logic [LW-1:0] start_ptr(input logic rev, input logic [LW-1:0] len);
        return rev ? len - ONE : '0;
    endfunction

    assign press = btn & ~btn_q;
    // A tick is never issued while the previous codec pulse or an overdub is in flight.
    assign tick  = read_ready & write_ready & ~pulse_q & ~od_busy;

    // Next-state logic: tick bookkeeping first, then a button press overrides state/pointer.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        pulse_d = 1'b0;
        we_d    = od_we;
        re_d    = 1'b0;
        addr_d  = od_hold ? addr_q : ptr_q[ADDR_W-1:0];
        // A press that coincides with a record tick counts that final write.
        rec_len = tick ? ptr_q + ONE : ptr_q;

        if (clear) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            len_d   = '0;
        end else begin
            if (tick) begin
                pulse_d = 1'b1;
                case (state_q)
                    ST_RECORD: begin
                        we_d = 1'b1;
                        if (ptr_q == MAX_LEN_C - ONE) begin
                            state_d = ST_PLAY;
                            len_d   = MAX_LEN_C;
                            ptr_d   = start_ptr(reverse, MAX_LEN_C);
                        end else begin
                            ptr_d = ptr_q + ONE;
                        end
                    end
                    ST_PLAY: begin
                        re_d = 1'b1;
                        if (reverse)
                            ptr_d = (ptr_q == '0) ? len_q - ONE : ptr_q - ONE;
                        else
                            ptr_d = (ptr_q == len_q - ONE) ? '0 : ptr_q + ONE;
                    end
                    default: ;
                endcase
            end

            if (press) begin
                case (state_q)
                    ST_IDLE: begin
                        if (len_q == '0) begin
                            state_d = ST_RECORD;
                            ptr_d   = '0;
                        end else begin
                            state_d = ST_PLAY;
                            ptr_d   = start_ptr(reverse, len_q);
                        end
                    end
                    ST_RECORD: begin
                        len_d = rec_len;
                        if (rec_len == '0) begin
                            state_d = ST_IDLE;
                            ptr_d   = '0;
                        end else begin
                            state_d = ST_PLAY;
                            ptr_d   = start_ptr(reverse, rec_len);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                    end
                endcase
            end
        end
    end

    // Registered FSM state, pointer, loop length and the one-cycle strobes.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            btn_q   <= 1'b0;
            pulse_q <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            btn_q   <= btn;
            pulse_q <= pulse_d;
            we_q    <= we_d;
            re_q    <= re_d;
        end
    end

`ifdef LOOP_OVERDUB_EN
    logic [1:0] od_q, od_d;
    logic       mix_q;

    // Overdub stage counter: 1 = read, 2 = datapath mixes, 3 = write back.
    always_comb begin
        od_d = 2'd0;
        if (od_q != 2'd0)
            od_d = od_q + 2'd1;
        else if (tick && !clear && (state_q == ST_PLAY) && overdub)
            od_d = 2'd1;
    end

    // Overdub stage register and the mix enable that accompanies the write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            od_q  <= 2'd0;
            mix_q <= 1'b0;
        end else begin
            od_q  <= od_d;
            mix_q <= od_we;
        end
    end

    assign od_busy = (od_q != 2'd0);
    assign od_hold = (od_q == 2'd1) || (od_q == 2'd2);
    assign od_we   = (od_q == 2'd2);
    assign mix_en  = mix_q;
`else
    logic unused_overdub;

    assign unused_overdub = overdub;
    assign od_busy        = 1'b0;
    assign od_hold        = 1'b0;
    assign od_we          = 1'b0;
    assign mix_en         = 1'b0;
`endif

    assign codec_read  = pulse_q;
    assign codec_write = pulse_q;
    assign mem_we      = we_q;
    assign mem_re      = re_q;
    assign mem_addr    = addr_q;
    assign loop_len    = len_q;
    assign state       = state_q;
    assign play_valid  = (state_q == ST_PLAY);

endmodule
